// File: rtl/servo_pkg.sv
// ----------------------------------------------------------------------------
// servo_pkg
//   Shared definitions for the servo latch sequencer and its arbiter.
//   - DUTY_W         : width of the shared duty bus
//   - BASE_CLOCK_HZ  : system clock frequency
//   - PWM_CLOCK_HZ   : divided clock the servo PWM generators run on
//   - MIN_LATCH_CYCLES : system cycles in one PWM tick, rounded up; the latch
//                        pulse must be at least this long to be captured
//   - seq_state_e    : sequencer FSM encoding
//   - clamp_duty()   : saturates a duty value into [lo, hi]
// ----------------------------------------------------------------------------
package servo_pkg;

    localparam int DUTY_W           = 8;
    localparam int BASE_CLOCK_HZ    = 50_000_000;
    localparam int PWM_CLOCK_HZ     = 128_000;
    localparam int MIN_LATCH_CYCLES = (BASE_CLOCK_HZ + PWM_CLOCK_HZ - 1) / PWM_CLOCK_HZ;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_LATCH = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] value,
        input logic [DUTY_W-1:0] lo,
        input logic [DUTY_W-1:0] hi
    );
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/servo_rr_arbiter.sv
// ----------------------------------------------------------------------------
// servo_rr_arbiter
//   Combinational round-robin pick: grants the first asserted request at or
//   after 'pointer', wrapping around. The pointer register is owned by the
//   caller, which advances it past the granted source.
// Ports
//   req        in   REQUESTERS  request vector
//   pointer    in   IW          highest-priority index this cycle
//   enable     in   1           no grant is issued while low
//   grant      out  REQUESTERS  one-hot grant, or zero
//   grant_idx  out  IW          index of the granted source (0 when no grant)
// ----------------------------------------------------------------------------
module servo_rr_arbiter #(
    parameter  int REQUESTERS = 2,
    localparam int IW         = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IW-1:0]         pointer,
    input  logic                  enable,
    output logic [REQUESTERS-1:0] grant,
    output logic [IW-1:0]         grant_idx
);

    logic found;
    int   idx;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = (int'(pointer) + k) % REQUESTERS;
            if (enable && !found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/servo_latch_sequencer.sv
// ----------------------------------------------------------------------------
// servo_latch_sequencer
//   Shares one duty bus and a set of per-channel latch lines between several
//   command sources. Sources are arbitrated round-robin; each accepted
//   (channel, duty) command plays out as duty setup -> latch pulse -> duty
//   hold, with the latch pulse long enough for the divided-clock PWM
//   generators to sample it.
// Ports (CW = $clog2(CHANNELS), min 1)
//   clock        in   1               system clock
//   reset        in   1               asynchronous, active-high
//   req_valid    in   REQUESTERS      per-source command valid
//   req_channel  in   REQUESTERS*CW   source r channel at [r*CW +: CW]
//   req_duty     in   REQUESTERS*8    source r duty at [r*8 +: 8]
//   req_ready    out  REQUESTERS      accept strobe (combinational, IDLE only)
//   duty         out  8               shared duty bus, keeps last applied value
//   latch        out  CHANNELS        per-channel latch, at most one bit high
//   busy         out  1               high outside IDLE
//   chan_err     out  1               one-cycle pulse after an out-of-range
//                                     channel is accepted
// Build option
//   SERVO_CLAMP_EN : when defined, accepted duty is clamped to
//                    [DUTY_MIN, DUTY_MAX]; otherwise it passes unchanged.
// ----------------------------------------------------------------------------
module servo_latch_sequencer
    import servo_pkg::*;
#(
    parameter  int CHANNELS     = 4,
    parameter  int REQUESTERS   = 2,
    parameter  int SETUP_CYCLES = 2,
    parameter  int LATCH_CYCLES = 400,
    parameter  int HOLD_CYCLES  = 2,
    parameter  int DUTY_MIN     = 0,
    parameter  int DUTY_MAX     = 255,
    localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [REQUESTERS-1:0]    req_valid,
    input  logic [REQUESTERS*CW-1:0] req_channel,
    input  logic [REQUESTERS*8-1:0]  req_duty,
    output logic [REQUESTERS-1:0]    req_ready,
    output logic [DUTY_W-1:0]        duty,
    output logic [CHANNELS-1:0]      latch,
    output logic                     busy,
    output logic                     chan_err
);

    localparam int IW        = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int MAX_SL    = (SETUP_CYCLES > LATCH_CYCLES) ? SETUP_CYCLES : LATCH_CYCLES;
    localparam int MAX_PHASE = (MAX_SL > HOLD_CYCLES) ? MAX_SL : HOLD_CYCLES;
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);

    seq_state_e           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]        chan_q, chan_d;
    logic [DUTY_W-1:0]    duty_q, duty_d;
    logic [CHANNELS-1:0]  latch_q, latch_d;
    logic                 busy_q, busy_d;
    logic                 chan_err_q, chan_err_d;

    logic [REQUESTERS-1:0] grant;
    logic [IW-1:0]         grant_idx;
    logic [CW-1:0]         sel_chan;
    logic [DUTY_W-1:0]     sel_duty;
    logic [DUTY_W-1:0]     cap_duty;

    servo_rr_arbiter #(
        .REQUESTERS (REQUESTERS)
    ) u_arb (
        .req       (req_valid),
        .pointer   (ptr_q),
        .enable    (state_q == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Accept strobe is the arbiter grant itself; it can only be non-zero in IDLE.
    assign req_ready = grant;
    assign sel_chan  = req_channel[int'(grant_idx)*CW +: CW];
    assign sel_duty  = req_duty[int'(grant_idx)*8 +: 8];

`ifdef SERVO_CLAMP_EN
    if (DUTY_MIN > DUTY_MAX) begin : g_bad_clamp_range
        $error("servo_latch_sequencer: DUTY_MIN must not exceed DUTY_MAX");
    end
    assign cap_duty = clamp_duty(sel_duty, DUTY_W'(DUTY_MIN), DUTY_W'(DUTY_MAX));
`else
    // Clamp bounds are accepted as parameters but have no effect in this build.
    if (DUTY_MIN > DUTY_MAX) begin : g_clamp_bounds_ignored
    end
    assign cap_duty = sel_duty;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        chan_d     = chan_q;
        duty_d     = duty_q;
        chan_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant != '0) begin
                    ptr_d = (grant_idx == IW'(REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
                    if (int'(sel_chan) < CHANNELS) begin
                        chan_d  = sel_chan;
                        duty_d  = cap_duty;
                        cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                        state_d = ST_SETUP;
                    end else begin
                        // Rejected command: flag it and keep the duty bus as is.
                        chan_err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(LATCH_CYCLES - 1);
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LATCH: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase

        // Outputs are decoded from the next state so they are registered and
        // line up exactly with the state they belong to.
        busy_d = (state_d != ST_IDLE);
        for (int c = 0; c < CHANNELS; c++) begin
            latch_d[c] = (state_d == ST_LATCH) && (int'(chan_d) == c);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            chan_q     <= '0;
            duty_q     <= '0;
            latch_q    <= '0;
            busy_q     <= 1'b0;
            chan_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            chan_q     <= chan_d;
            duty_q     <= duty_d;
            latch_q    <= latch_d;
            busy_q     <= busy_d;
            chan_err_q <= chan_err_d;
        end
    end

    assign duty     = duty_q;
    assign latch    = latch_q;
    assign busy     = busy_q;
    assign chan_err = chan_err_q;

endmodule
